// File: rtl/key_arbiter.sv
// key_arbiter
//   Turns raw, bouncing note buttons into a single clean monophonic key selection.
//   Pipeline: 2-flop synchroniser -> per-key debounce -> press/release event pulses
//   -> last-note-priority FSM with registered outputs.
//
// Ports
//   clk         system clock, all flops on rising edge
//   rst         asynchronous, active-high reset
//   button_raw  raw asynchronous buttons, 1 = pressed (bit 0 = C4)
//   key_onehot  selected key, one-hot or all-zero
//   key_idx     binary index of the selected key (0 when none)
//   gate        1 while the note is sounding
//   new_note    1-cycle strobe when key_onehot takes a new nonzero value
module key_arbiter #(
    parameter int unsigned N_KEYS     = 12,
    parameter int unsigned DB_LIMIT   = 50000,
    parameter int unsigned RETRIG_GAP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] button_raw,
    output logic [N_KEYS-1:0] key_onehot,
    output logic [3:0]        key_idx,
    output logic              gate,
    output logic              new_note
);

    localparam int unsigned CW       = $clog2(DB_LIMIT + 1);
    localparam int unsigned CNT_LAST = DB_LIMIT - 1;
    localparam int unsigned GW       = (RETRIG_GAP > 1) ? $clog2(RETRIG_GAP) : 1;
    localparam int unsigned GAP_LAST = (RETRIG_GAP > 0) ? RETRIG_GAP - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } state_t;

    // Synchroniser and debounce state
    logic [N_KEYS-1:0] meta_q, sync_q;
    logic [N_KEYS-1:0] stable_q, stable_d;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;

    // Arbiter state
    state_t            state_q, state_d;
    logic [N_KEYS-1:0] sel_q, sel_d;
    logic [3:0]        idx_q, idx_d;
    logic              gate_q, gate_d;
    logic              new_note_q, new_note_d;
    logic [GW-1:0]     gap_q, gap_d;

    function automatic logic [N_KEYS-1:0] lowest_bit(input logic [N_KEYS-1:0] v);
        return v & (~v + N_KEYS'(1));
    endfunction

    function automatic logic [3:0] encode(input logic [N_KEYS-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Debounce: the counter only runs while sync disagrees with stable; the edge
    // that would take it to DB_LIMIT flips stable instead and clears it.
    always_comb begin
        stable_d = stable_q;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            cnt_d[k] = '0;
            if (sync_q[k] != stable_q[k]) begin
                if (cnt_q[k] == CW'(CNT_LAST)) begin
                    stable_d[k] = ~stable_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end
        end
        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            meta_q    <= button_raw;
            sync_q    <= meta_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Arbiter next-state. Events are registered, so stable_q already reflects
    // them when the FSM acts; a release leaves stable_q holding only the keys
    // still down, which is exactly the fallback candidate set.
    always_comb begin
        logic              take_new;
        logic [N_KEYS-1:0] next_key;

        state_d    = state_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        gate_d     = gate_q;
        new_note_d = 1'b0;
        gap_d      = gap_q;
        take_new   = 1'b0;
        next_key   = '0;

        case (state_q)
            IDLE: begin
                if (|press_q) begin
                    take_new = 1'b1;
                    next_key = lowest_bit(press_q);
                end
            end
            PLAY, GAP: begin
                if (|press_q) begin
                    take_new = 1'b1;
                    next_key = lowest_bit(press_q);
                end else if (|(release_q & sel_q)) begin
                    if (|stable_q) begin
                        take_new = 1'b1;
                        next_key = lowest_bit(stable_q);
                    end else begin
                        state_d = IDLE;
                        sel_d   = '0;
                        idx_d   = '0;
                        gate_d  = 1'b0;
                        gap_d   = '0;
                    end
                end else if (state_q == GAP) begin
                    gap_d = gap_q + GW'(1);
                    if (gap_q == GW'(GAP_LAST)) begin
                        state_d = PLAY;
                        gate_d  = 1'b1;
                        gap_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                idx_d   = '0;
                gate_d  = 1'b0;
                gap_d   = '0;
            end
        endcase

        if (take_new) begin
            sel_d      = next_key;
            idx_d      = encode(next_key);
            new_note_d = 1'b1;
            gap_d      = '0;
            if (state_q != IDLE && RETRIG_GAP > 0) begin
                state_d = GAP;
                gate_d  = 1'b0;
            end else begin
                state_d = PLAY;
                gate_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            idx_q      <= '0;
            gate_q     <= 1'b0;
            new_note_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            gate_q     <= gate_d;
            new_note_q <= new_note_d;
            gap_q      <= gap_d;
        end
    end

    assign key_onehot = sel_q;
    assign key_idx    = idx_q;
    assign gate       = gate_q;
    assign new_note   = new_note_q;

endmodule

// File: tb/tb_key_arbiter.sv
// tb_key_arbiter
//   Directed bench for key_arbiter with DB_LIMIT=4, RETRIG_GAP=2.
//   A vector table covers press/priority/fallback/gap timing; hand-written
//   sequences cover reset, glitch rejection and asynchronous reset mid-gap.
module tb_key_arbiter;

    logic        clk;
    logic        rst;
    logic [11:0] button_raw;
    logic [11:0] key_onehot;
    logic [3:0]  key_idx;
    logic        gate;
    logic        new_note;

    key_arbiter #(
        .N_KEYS    (12),
        .DB_LIMIT  (4),
        .RETRIG_GAP(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button_raw(button_raw),
        .key_onehot(key_onehot),
        .key_idx   (key_idx),
        .gate      (gate),
        .new_note  (new_note)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] raw;
        int unsigned n_wait;
        logic [11:0] oh;
        logic [3:0]  idx;
        logic        gate;
        logic        nn;
    } vec_t;

    vec_t vecs [17];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic [11:0] oh, input logic [3:0] idx,
                           input logic g, input logic nn);
        chk({tag, ".key_onehot"}, key_onehot, oh);
        chk({tag, ".key_idx"}, {8'h0, key_idx}, {8'h0, idx});
        chk({tag, ".gate"}, {11'h0, gate}, {11'h0, g});
        chk({tag, ".new_note"}, {11'h0, new_note}, {11'h0, nn});
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vecs(input int unsigned first, input int unsigned last);
        for (int unsigned i = first; i <= last; i++) begin
            button_raw = vecs[i].raw;
            cyc(vecs[i].n_wait);
            chk_all($sformatf("vec%0d", i), vecs[i].oh, vecs[i].idx, vecs[i].gate, vecs[i].nn);
        end
    endtask

    initial begin
        // Add A to held C4, gap of 2 cycles
        vecs[0]  = '{12'h201, 6, 12'h001, 4'd0, 1'b1, 1'b0};
        vecs[1]  = '{12'h201, 1, 12'h200, 4'd9, 1'b0, 1'b1};
        vecs[2]  = '{12'h201, 1, 12'h200, 4'd9, 1'b0, 1'b0};
        vecs[3]  = '{12'h201, 1, 12'h200, 4'd9, 1'b1, 1'b0};
        // Release A -> fall back to C4, then release C4 -> idle
        vecs[4]  = '{12'h001, 6, 12'h200, 4'd9, 1'b1, 1'b0};
        vecs[5]  = '{12'h001, 1, 12'h001, 4'd0, 1'b0, 1'b1};
        vecs[6]  = '{12'h001, 1, 12'h001, 4'd0, 1'b0, 1'b0};
        vecs[7]  = '{12'h001, 1, 12'h001, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{12'h000, 6, 12'h001, 4'd0, 1'b1, 1'b0};
        vecs[9]  = '{12'h000, 1, 12'h000, 4'd0, 1'b0, 1'b0};
        vecs[10] = '{12'h000, 1, 12'h000, 4'd0, 1'b0, 1'b0};
        // Simultaneous press of bits 2 and 7 from idle
        vecs[11] = '{12'h084, 6, 12'h000, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{12'h084, 1, 12'h004, 4'd2, 1'b1, 1'b1};
        vecs[13] = '{12'h084, 1, 12'h004, 4'd2, 1'b1, 1'b0};
        vecs[14] = '{12'h000, 7, 12'h000, 4'd0, 1'b0, 1'b0};
        // C4 from idle, then D# press lands in GAP
        vecs[15] = '{12'h001, 7, 12'h001, 4'd0, 1'b1, 1'b1};
        vecs[16] = '{12'h009, 7, 12'h008, 4'd3, 1'b0, 1'b1};

        // Reset with all buttons held
        rst = 1'b1;
        button_raw = 12'hFFF;
        #1;
        chk_all("rst_async", 12'h000, 4'd0, 1'b0, 1'b0);
        cyc(3);
        chk_all("rst_hold", 12'h000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        button_raw = 12'h001;
        cyc(6);
        chk_all("c4_edge6", 12'h000, 4'd0, 1'b0, 1'b0);
        cyc(1);
        chk_all("c4_edge7", 12'h001, 4'd0, 1'b1, 1'b1);
        cyc(1);
        chk_all("c4_edge8", 12'h001, 4'd0, 1'b1, 1'b0);

        run_vecs(0, 10);

        // Glitching bit 4 with 3-cycle highs/lows must never register
        for (int unsigned c = 0; c < 40; c++) begin
            button_raw = ((c / 3) % 2 == 0) ? 12'h010 : 12'h000;
            cyc(1);
            chk($sformatf("glitch%0d.key_onehot", c), key_onehot, 12'h000);
            chk($sformatf("glitch%0d.new_note", c), {11'h0, new_note}, 12'h000);
        end
        button_raw = 12'h000;
        cyc(8);
        chk_all("glitch_end", 12'h000, 4'd0, 1'b0, 1'b0);

        run_vecs(11, 16);

        // Asynchronous reset while in GAP
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_mid_gap", 12'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        button_raw = 12'h008;
        cyc(6);
        chk_all("ds_edge6", 12'h000, 4'd0, 1'b0, 1'b0);
        cyc(1);
        chk_all("ds_edge7", 12'h008, 4'd3, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
